// File: rtl/xadc_pair_sampler.sv
// ============================================================================
// Module   : xadc_pair_sampler
// Brief    : On each XADC end-of-conversion, reads the switch and feed channels
//            over DRP and presents both 12-bit results as one valid/ready pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xadc_pair_sampler #(
  parameter logic [6:0] SWITCH_ADDR = 7'h10,
  parameter logic [6:0] FEED_ADDR   = 7'h11,
  parameter int         DRP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        eoc,
  output logic        drp_den,
  output logic [6:0]  drp_daddr,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pair_valid,
  input  logic        pair_ready,
  output logic [11:0] switch_sample,
  output logic [11:0] feed_sample,
  output logic [15:0] overrun_cnt,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_SW = 3'd1,
    WT_SW = 3'd2,
    RD_FD = 3'd3,
    WT_FD = 3'd4
  } state_t;

  // The counter is zero in the first wait cycle, so the abandon decision lands
  // DRP_TIMEOUT-1 cycles after den and timeout_err shows DRP_TIMEOUT after it.
  localparam logic [7:0] C_LIMIT = 8'(DRP_TIMEOUT - 2);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [11:0] r_sw_hold;
  logic        r_den;
  logic [6:0]  r_daddr;
  logic        r_timeout;
  logic        r_pair_valid;
  logic [11:0] r_switch;
  logic [11:0] r_feed;
  logic [15:0] r_overrun;

  logic        w_limit;
  logic        w_done;
  logic        w_load;
  logic        w_drop;
  logic        w_eoc_ovr;
  logic [16:0] w_sum;
  logic        w_unused;

  assign w_limit   = (r_cnt == C_LIMIT);
  assign w_done    = (r_state == WT_FD) && drp_drdy;
  assign w_load    = w_done && (!r_pair_valid || pair_ready);
  assign w_drop    = w_done && !w_load;
  assign w_eoc_ovr = eoc && (r_state != IDLE);
  assign w_sum     = {1'b0, r_overrun} + {16'd0, w_drop} + {16'd0, w_eoc_ovr};
  assign w_unused  = &{1'b0, drp_do[3:0]};

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sw_hold <= '0;
      r_den     <= 1'b0;
      r_daddr   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_den     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (eoc) begin
            r_state <= RD_SW;
            r_den   <= 1'b1;
            r_daddr <= SWITCH_ADDR;
          end
        end
        RD_SW: begin
          r_cnt   <= '0;
          r_state <= WT_SW;
        end
        WT_SW: begin
          if (drp_drdy) begin
            r_sw_hold <= drp_do[15:4];
            r_state   <= RD_FD;
            r_den     <= 1'b1;
            r_daddr   <= FEED_ADDR;
          end else if (w_limit) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RD_FD: begin
          r_cnt   <= '0;
          r_state <= WT_FD;
        end
        WT_FD: begin
          if (drp_drdy) begin
            r_state <= IDLE;
          end else if (w_limit) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Single-entry output register; a completed pair that cannot be stored is dropped.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pair_valid <= 1'b0;
      r_switch     <= '0;
      r_feed       <= '0;
      r_overrun    <= '0;
    end else begin
      if (w_load) begin
        r_pair_valid <= 1'b1;
        r_switch     <= r_sw_hold;
        r_feed       <= drp_do[15:4];
      end else if (r_pair_valid && pair_ready) begin
        r_pair_valid <= 1'b0;
      end
      r_overrun <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign drp_den       = r_den;
  assign drp_daddr     = r_daddr;
  assign timeout_err   = r_timeout;
  assign pair_valid    = r_pair_valid;
  assign switch_sample = r_switch;
  assign feed_sample   = r_feed;
  assign overrun_cnt   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_xadc_pair_sampler.sv
// ============================================================================
// Module   : tb_xadc_pair_sampler
// Brief    : Directed self-checking bench with a delay-programmable DRP responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xadc_pair_sampler;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        eoc = 1'b0;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0;
  logic        pair_valid;
  logic        pair_ready = 1'b0;
  logic [11:0] switch_sample;
  logic [11:0] feed_sample;
  logic [15:0] overrun_cnt;
  logic        timeout_err;

  int passed = 0;
  int total  = 0;

  xadc_pair_sampler #(
    .SWITCH_ADDR(7'h10),
    .FEED_ADDR  (7'h11),
    .DRP_TIMEOUT(8)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .eoc          (eoc),
    .drp_den      (drp_den),
    .drp_daddr    (drp_daddr),
    .drp_do       (drp_do),
    .drp_drdy     (drp_drdy),
    .pair_valid   (pair_valid),
    .pair_ready   (pair_ready),
    .switch_sample(switch_sample),
    .feed_sample  (feed_sample),
    .overrun_cnt  (overrun_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // DRP responder: answers a den after m_delay cycles unless that channel is muted
  int          m_delay = 3;
  logic        m_mute_sw = 1'b0;
  logic        m_mute_fd = 1'b0;
  logic [15:0] m_sw_data = '0;
  logic [15:0] m_fd_data = '0;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_data = '0;

  always @(negedge clk) begin
    drp_drdy = 1'b0;
    if (m_pend) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        drp_drdy = 1'b1;
        drp_do   = m_data;
        m_pend   = 1'b0;
      end
    end
    if (drp_den) begin
      if (drp_daddr == 7'h10 && !m_mute_sw) begin
        m_pend = 1'b1; m_cnt = m_delay; m_data = m_sw_data;
      end else if (drp_daddr == 7'h11 && !m_mute_fd) begin
        m_pend = 1'b1; m_cnt = m_delay; m_data = m_fd_data;
      end
    end
  end

  // Per-cycle observation record
  int          cyc, nden, nval, nto, fd_den_idx, val_idx, to_idx, first_den_idx;
  logic [6:0]  addr_log [8];
  logic [11:0] sw_cap, fd_cap;

  task automatic clear_stats();
    cyc = 0; nden = 0; nval = 0; nto = 0;
    fd_den_idx = -1; val_idx = -1; to_idx = -1; first_den_idx = -1;
    sw_cap = '0; fd_cap = '0;
    for (int i = 0; i < 8; i++) addr_log[i] = '0;
  endtask

  task automatic tick(input logic e);
    @(negedge clk);
    if (drp_den) begin
      if (nden < 8) addr_log[nden] = drp_daddr;
      if (first_den_idx < 0) first_den_idx = cyc;
      if (drp_daddr == 7'h11 && fd_den_idx < 0) fd_den_idx = cyc;
      nden++;
    end
    if (pair_valid) begin
      if (val_idx < 0) begin
        val_idx = cyc; sw_cap = switch_sample; fd_cap = feed_sample;
      end
      nval++;
    end
    if (timeout_err) begin
      if (to_idx < 0) to_idx = cyc;
      nto++;
    end
    eoc = e;
    cyc++;
  endtask

  task automatic do_reset();
    clr = 1'b1; eoc = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; eoc = 1'b0; pair_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (pair_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", pair_valid); else passed++;
    total++; if (drp_den !== 1'b0) $display("FAIL rst_den: got %b expected 0", drp_den); else passed++;
    total++; if (drp_daddr !== 7'h00) $display("FAIL rst_daddr: got %h expected 00", drp_daddr); else passed++;
    total++; if ({switch_sample, feed_sample} !== 24'h0) $display("FAIL rst_samples: got %h expected 000000", {switch_sample, feed_sample}); else passed++;
    total++; if (overrun_cnt !== 16'h0) $display("FAIL rst_overrun: got %h expected 0000", overrun_cnt); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout: got %b expected 0", timeout_err); else passed++;
    clr = 1'b0;
  endtask

  task automatic test_basic();
    pair_ready = 1'b1; m_delay = 3; m_sw_data = 16'hABC0; m_fd_data = 16'h1230;
    clear_stats();
    for (int i = 0; i < 30; i++) tick(i == 0);
    total++; if (first_den_idx !== 1) $display("FAIL basic_den_latency: got %0d expected 1", first_den_idx); else passed++;
    total++; if (nden !== 2) $display("FAIL basic_den_count: got %0d expected 2", nden); else passed++;
    total++; if ({addr_log[0], addr_log[1]} !== {7'h10, 7'h11}) $display("FAIL basic_addrs: got %h,%h expected 10,11", addr_log[0], addr_log[1]); else passed++;
    total++; if (val_idx !== 9) $display("FAIL basic_valid_latency: got %0d expected 9", val_idx); else passed++;
    total++; if (nval !== 1) $display("FAIL basic_valid_cycles: got %0d expected 1", nval); else passed++;
    total++; if (sw_cap !== 12'hABC) $display("FAIL basic_switch: got %h expected ABC", sw_cap); else passed++;
    total++; if (fd_cap !== 12'h123) $display("FAIL basic_feed: got %h expected 123", fd_cap); else passed++;
    total++; if (overrun_cnt !== 16'h0) $display("FAIL basic_overrun: got %h expected 0000", overrun_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    int unstable;
    do_reset();
    pair_ready = 1'b0; m_delay = 3; m_sw_data = 16'h1000; m_fd_data = 16'h2000;
    clear_stats();
    for (int i = 0; i < 15; i++) tick(i == 0);
    total++; if ({pair_valid, sw_cap, fd_cap} !== {1'b1, 12'h100, 12'h200}) $display("FAIL bp_first_pair: got %b %h %h expected 1 100 200", pair_valid, sw_cap, fd_cap); else passed++;
    m_sw_data = 16'h3000; m_fd_data = 16'h4000;
    unstable = 0;
    clear_stats();
    for (int i = 0; i < 15; i++) begin
      tick(i == 0);
      if ({pair_valid, switch_sample, feed_sample} !== {1'b1, 12'h100, 12'h200}) unstable++;
    end
    total++; if (unstable !== 0) $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", unstable); else passed++;
    total++; if (overrun_cnt !== 16'd1) $display("FAIL bp_overrun: got %0d expected 1", overrun_cnt); else passed++;
    // eoc coincides with the dropped completion: both events count
    clear_stats();
    for (int i = 0; i < 15; i++) tick(i == 0 || i == 8);
    total++; if (overrun_cnt !== 16'd3) $display("FAIL bp_double_count: got %0d expected 3", overrun_cnt); else passed++;
    total++; if ({switch_sample, feed_sample} !== {12'h100, 12'h200}) $display("FAIL bp_still_first: got %h %h expected 100 200", switch_sample, feed_sample); else passed++;
    tick(1'b0);
    pair_ready = 1'b1;
    tick(1'b0);
    pair_ready = 1'b0;
    total++; if (pair_valid !== 1'b0) $display("FAIL bp_after_accept: got %b expected 0", pair_valid); else passed++;
    repeat (3) tick(1'b0);
    total++; if (pair_valid !== 1'b0) $display("FAIL bp_stays_empty: got %b expected 0", pair_valid); else passed++;
  endtask

  task automatic test_early_eoc();
    do_reset();
    pair_ready = 1'b1; m_delay = 5; m_sw_data = 16'h5550; m_fd_data = 16'h6660;
    clear_stats();
    for (int i = 0; i < 30; i++) tick(i == 0 || i == 3);
    total++; if (overrun_cnt !== 16'd1) $display("FAIL early_overrun: got %0d expected 1", overrun_cnt); else passed++;
    total++; if (nden !== 2) $display("FAIL early_den_count: got %0d expected 2", nden); else passed++;
    total++; if (val_idx !== 13) $display("FAIL early_valid_cycle: got %0d expected 13", val_idx); else passed++;
    total++; if ({sw_cap, fd_cap} !== {12'h555, 12'h666}) $display("FAIL early_pair: got %h %h expected 555 666", sw_cap, fd_cap); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    pair_ready = 1'b1; m_delay = 3; m_mute_fd = 1'b1; m_sw_data = 16'h1110; m_fd_data = 16'h2220;
    clear_stats();
    for (int i = 0; i < 25; i++) tick(i == 0);
    m_mute_fd = 1'b0;
    total++; if (fd_den_idx !== 5) $display("FAIL to_fd_den_cycle: got %0d expected 5", fd_den_idx); else passed++;
    total++; if (to_idx - fd_den_idx !== 8) $display("FAIL to_delay: got %0d expected 8", to_idx - fd_den_idx); else passed++;
    total++; if (nto !== 1) $display("FAIL to_pulse_count: got %0d expected 1", nto); else passed++;
    total++; if (nval !== 0) $display("FAIL to_no_pair: got %0d expected 0", nval); else passed++;
    // drdy exactly on the limit cycle of both reads is still accepted
    m_delay = 7; m_sw_data = 16'h7770; m_fd_data = 16'h8880;
    clear_stats();
    for (int i = 0; i < 30; i++) tick(i == 0);
    total++; if ({first_den_idx, 25'd0, addr_log[0]} !== {32'sd1, 25'd0, 7'h10}) $display("FAIL to_fresh_sw_read: got %0d %h expected 1 10", first_den_idx, addr_log[0]); else passed++;
    total++; if (nto !== 0) $display("FAIL to_limit_success: got %0d timeouts expected 0", nto); else passed++;
    total++; if ({val_idx, sw_cap, fd_cap} !== {32'sd17, 12'h777, 12'h888}) $display("FAIL to_limit_pair: got %0d %h %h expected 17 777 888", val_idx, sw_cap, fd_cap); else passed++;
    // one cycle too late: abandoned, and the late drdy lands in IDLE
    m_delay = 8;
    clear_stats();
    for (int i = 0; i < 25; i++) tick(i == 0);
    total++; if ({nto, nden, nval} !== {32'sd1, 32'sd1, 32'sd0}) $display("FAIL to_late_by_one: got to=%0d den=%0d val=%0d expected 1 1 0", nto, nden, nval); else passed++;
    total++; if (to_idx !== 9) $display("FAIL to_sw_cycle: got %0d expected 9", to_idx); else passed++;
  endtask

  task automatic test_reset_mid_read();
    logic [55:0] snap;
    snap = '1;
    pair_ready = 1'b1; m_delay = 6; m_sw_data = 16'h9990; m_fd_data = 16'hAAA0;
    clear_stats();
    for (int i = 0; i < 30; i++) begin
      tick(i == 0 || i == 3);
      if (i == 12) snap = {pair_valid, drp_den, drp_daddr, switch_sample, feed_sample, overrun_cnt, timeout_err, 6'd0};
      clr = (i == 10 || i == 11);
    end
    clr = 1'b0;
    total++; if (snap !== 56'd0) $display("FAIL rmid_outputs_zero: got %h expected 0", snap); else passed++;
    total++; if ({nval, nden, nto} !== {32'sd0, 32'sd2, 32'sd0}) $display("FAIL rmid_no_pair: got val=%0d den=%0d to=%0d expected 0 2 0", nval, nden, nto); else passed++;
    total++; if ({pair_valid, switch_sample, feed_sample} !== 25'd0) $display("FAIL rmid_late_drdy: got %b %h %h expected 0 000 000", pair_valid, switch_sample, feed_sample); else passed++;
    clear_stats();
    for (int i = 0; i < 25; i++) tick(i == 0);
    total++; if ({first_den_idx, val_idx} !== {32'sd1, 32'sd15}) $display("FAIL rmid_restart: got den=%0d val=%0d expected 1 15", first_den_idx, val_idx); else passed++;
    total++; if ({sw_cap, fd_cap} !== {12'h999, 12'hAAA}) $display("FAIL rmid_pair: got %h %h expected 999 AAA", sw_cap, fd_cap); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    m_mute_sw = 1'b1;
    // Muted reads cycle every 9 cycles with 8 counted eoc events: 72000 total
    @(negedge clk); eoc = 1'b1;
    repeat (81000) @(negedge clk);
    eoc = 1'b0;
    repeat (2) @(negedge clk);
    m_mute_sw = 1'b0;
    total++; if (overrun_cnt !== 16'hFFFF) $display("FAIL sat_overrun: got %h expected FFFF", overrun_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_early_eoc();
    test_timeout();
    test_reset_mid_read();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
